// File: rtl/fabric_row_loader_pkg.sv
// Shared types and widths for the fabric row loader.
package fabric_row_loader_pkg;

    localparam int unsigned INSTR_DATA_WIDTH = 32;
    localparam int unsigned INSTR_ADDR_WIDTH = 4;
    localparam int unsigned INSTR_HOPS_WIDTH = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StFlush   = 3'd2,
        StCall    = 3'd3,
        StGuard   = 3'd4,
        StWaitRet = 3'd5,
        StDone    = 3'd6
    } state_e;

    // One buffered host word; col becomes the hop count on the chain.
    typedef struct packed {
        logic [INSTR_DATA_WIDTH-1:0] data;
        logic [INSTR_ADDR_WIDTH-1:0] addr;
        logic [INSTR_HOPS_WIDTH-1:0] col;
        logic                        last;
    } instr_word_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/fabric_row_loader_if.sv
// Host-side valid/ready word channel into the row loader.
interface fabric_row_loader_if;
    import fabric_row_loader_pkg::*;

    logic                        s_valid;
    logic                        s_ready;
    logic [INSTR_DATA_WIDTH-1:0] s_data;
    logic [INSTR_ADDR_WIDTH-1:0] s_addr;
    logic [INSTR_HOPS_WIDTH-1:0] s_col;
    logic                        s_last;

    modport master (
        output s_valid, s_data, s_addr, s_col, s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_addr, s_col, s_last,
        output s_ready
    );

endinterface

// File: rtl/fabric_row_loader_fifo.sv
// Synchronous first-word-fall-through FIFO of instruction words.
module fabric_row_loader_fifo
    import fabric_row_loader_pkg::*;
#(
    parameter int unsigned Depth = 8  // power of two, >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  instr_word_t wdata_i,
    input  logic        pop_i,
    output instr_word_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    instr_word_t mem_q [Depth];
    instr_word_t mem_d [Depth];
    logic        push_ok;
    logic        pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers.
    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    end

    // Storage is not reset; resetting the pointers discards its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/fabric_row_loader.sv
// Row-side initiator: buffers a host packet, streams it down the row's
// instruction chain, then runs the call/ret handshake and reports done.
module fabric_row_loader
    import fabric_row_loader_pkg::*;
#(
    parameter int unsigned COLS        = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned RET_GUARD   = 4,
    parameter int unsigned RET_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fabric_row_loader_if.slave          s,
    output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
    output logic                        instr_en_out,
    output logic                        call_out,
    input  logic                        ret_in,
    output logic                        busy,
    output logic                        done,
    output logic                        err_col,
    output logic                        err_timeout
);

    localparam int unsigned CNT_MAX   = max3(COLS, RET_GUARD, RET_TIMEOUT);
    localparam int unsigned CNT_WIDTH = $clog2(CNT_MAX + 1);

    state_e                      state_q, state_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        last_buf_q, last_buf_d;
    logic [INSTR_DATA_WIDTH-1:0] data_q, data_d;
    logic [INSTR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSTR_HOPS_WIDTH-1:0] hops_q, hops_d;
    logic                        en_q, en_d;
    logic                        call_q, call_d;
    logic                        done_q, done_d;
    logic                        err_col_q, err_col_d;
    logic                        err_timeout_q, err_timeout_d;

    logic        push, pop;
    logic        fifo_full, fifo_empty;
    instr_word_t wr_word, rd_word;
    logic        wr_bad, rd_ok;
    logic [31:0] cnt_plus1;

    assign s.s_ready = rst_n && !fifo_full && !last_buf_q &&
                       (state_q == StIdle || state_q == StLoad);
    assign push      = s.s_valid && s.s_ready;
    // IDLE pops as well so the first word hits the chain one cycle after it is accepted.
    assign pop       = (state_q == StIdle || state_q == StLoad) && !fifo_empty;
    assign wr_word   = '{data: s.s_data, addr: s.s_addr, col: s.s_col, last: s.s_last};
    assign wr_bad    = 32'(s.s_col) >= COLS;
    assign rd_ok     = 32'(rd_word.col) < COLS;
    assign cnt_plus1 = 32'(cnt_q) + 32'd1;

    fabric_row_loader_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wr_word),
        .pop_i   (pop),
        .rdata_o (rd_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FSM next-state, phase counter and registered-output next values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        data_d        = '0;
        addr_d        = '0;
        hops_d        = '0;
        en_d          = 1'b0;
        last_buf_d    = last_buf_q | (push & s.s_last);
        err_col_d     = err_col_q | (push & wr_bad);
        err_timeout_d = err_timeout_q;

        unique case (state_q)
            StIdle, StLoad: begin
                if (pop) begin
                    // Out-of-range columns are dropped but their last flag still ends the packet.
                    if (rd_ok) begin
                        en_d   = 1'b1;
                        data_d = rd_word.data;
                        addr_d = rd_word.addr;
                        hops_d = rd_word.col;
                    end
                    state_d = rd_word.last ? StFlush : StLoad;
                end
            end
            StFlush: begin
                if (cnt_plus1 >= COLS) state_d = StCall;
            end
            StCall: begin
                state_d = (RET_GUARD == 0) ? StWaitRet : StGuard;
            end
            StGuard: begin
                if (cnt_plus1 >= RET_GUARD) state_d = StWaitRet;
            end
            StWaitRet: begin
                if (ret_in) begin
                    state_d = StDone;
                end else if (RET_TIMEOUT != 0 && cnt_plus1 >= RET_TIMEOUT) begin
                    err_timeout_d = 1'b1;
                    state_d       = StDone;
                end
            end
            StDone: begin
                state_d    = StIdle;
                last_buf_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) cnt_d = '0;
        call_d = (state_d == StCall);
        done_d = (state_d == StDone);
    end

    // Single state register for the FSM and all of its registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            last_buf_q    <= 1'b0;
            data_q        <= '0;
            addr_q        <= '0;
            hops_q        <= '0;
            en_q          <= 1'b0;
            call_q        <= 1'b0;
            done_q        <= 1'b0;
            err_col_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_buf_q    <= last_buf_d;
            data_q        <= data_d;
            addr_q        <= addr_d;
            hops_q        <= hops_d;
            en_q          <= en_d;
            call_q        <= call_d;
            done_q        <= done_d;
            err_col_q     <= err_col_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign instr_data_out = data_q;
    assign instr_addr_out = addr_q;
    assign instr_hops_out = hops_q;
    assign instr_en_out   = en_q;
    assign call_out       = call_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign err_col        = err_col_q;
    assign err_timeout    = err_timeout_q;

endmodule
